// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and a frame-length helper.
// Used by the configurable receiver and the upcoming configurable transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Total serial bits in one frame, start bit included.
  function automatic int frame_bits(input int data_bits, input int parity_bits,
                                    input int stop_bits);
    return 1 + data_bits + parity_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for the asynchronous serial pin.
// Both flops reset to 1 so an idle-high line never looks like a start bit.
module uart_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, 1 or 2 stop bits, framing error reporting.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_data,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif
  localparam bit PARITY_ON = PARITY_BUILT && (PARITY_MODE != PARITY_NONE);

  uart_state_t          state;
  logic                 rx_s;
  logic                 rx_prev;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 frame_err_acc;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_acc;
`endif

  uart_bit_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_data),
    .q   (rx_s)
  );

  // Mid-bit sampling: START waits half a bit, every later state waits a full bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rx_prev       <= 1'b1;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      frame_err_acc <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_acc   <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state         <= DATA;
              idx           <= '0;
              frame_err_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
              par_err_acc   <= 1'b0;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (idx == LAST_DATA) begin
              idx   <= '0;
              state <= PARITY_ON ? PARITY : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt         <= '0;
            state       <= STOP;
            par_err_acc <= (PARITY_MODE == PARITY_ODD) ? ~(^shift ^ rx_s) : (^shift ^ rx_s);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (!rx_s) frame_err_acc <= 1'b1;
            if (idx == LAST_STOP) begin
              idx          <= '0;
              rx_valid     <= 1'b1;
              rx_data      <= shift;
              rx_frame_err <= frame_err_acc | ~rx_s;
`ifdef UART_RX_PARITY_EN
              rx_parity_err <= par_err_acc;
`endif
              // A low stop bit may be the start of a break; wait for the line to recover.
              if (frame_err_acc || !rx_s) begin
                state <= BREAK;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable data width, optional parity checking, one or two stop bits, input synchronisation, false-start rejection and framing/parity error reporting. Sits between the asynchronous serial pin and the byte-consuming logic, e.g. a command parser or RX FIFO. Single clock domain.

## Interface
- CLKS_PER_BIT, 868: clock cycles per serial bit, integer ≥ 4.
- DATA_BITS, 8: payload bits per frame, 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd. Ignored unless parity is compiled in.
- STOP_BITS, 1: number of stop bits, 1 or 2.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- serial_data  in  1  asynchronous serial line, idle high.
- rx_valid  out  1  one-cycle pulse: frame complete, rx_data and error flags valid.
- rx_data  out  DATA_BITS  received payload, LSB received first. Holds until the next rx_valid.
- rx_frame_err  out  1  stop bit sampled low. Qualified by rx_valid.
- rx_parity_err  out  1  parity mismatch. Qualified by rx_valid.
- rx_busy  out  1  high from start-bit detection until return to IDLE.

## Operation
- serial_data passes through a 2-FF synchroniser. Internal line signal is rx_s. All decisions use rx_s.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: a falling edge on rx_s goes to START and clears the bit counter cnt.
- START: wait until cnt = CLKS_PER_BIT/2 - 1 (integer division), then sample.
  - Sample low: go to DATA with cnt = 0.
  - Sample high: glitch. Return to IDLE with no rx_valid.
- DATA: sample each bit when cnt = CLKS_PER_BIT-1, then reset cnt. Shift bits into bit index idx, LSB first. After DATA_BITS samples, go to PARITY if parity is enabled and PARITY_MODE≠0, otherwise go to STOP.
- PARITY: sample one bit.
  - Even mode: error if the XOR of payload and parity bit is 1.
  - Odd mode: error if that XOR is 0.
- STOP: sample STOP_BITS bits. Any low stop bit sets the frame error.
  - After the last stop sample, pulse rx_valid in the next cycle and update rx_data and the error flags in that same cycle.
  - If all stop bits were high, go to IDLE. Otherwise go to BREAK.
- BREAK: wait for rx_s high, then go to IDLE. A line held low (break condition) produces exactly one errored frame.
- Falling edges on rx_s outside IDLE are ignored.
- The state machine resynchronises on each start bit, so back-to-back frames with no idle gap are accepted.

## Timing
- Reset values: rx_valid=0, rx_data=0, rx_frame_err=0, rx_parity_err=0, rx_busy=0, state=IDLE, synchroniser flops = 1.
- Reset asserted mid-frame aborts the frame. No rx_valid is issued. Receiver is ready one cycle after rst deasserts.
- Synchroniser adds 2 cycles of latency.
- rx_valid latency from the line falling edge is 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles, where P = 1 if parity is active, else 0.
- rx_valid is never high on two consecutive cycles.
- rx_busy falls in the same cycle rx_valid is high, unless the FSM enters BREAK.
- cnt width is $clog2(CLKS_PER_BIT). idx width is $clog2(DATA_BITS+1).

## Configuration
- UART_RX_PARITY_EN defined: PARITY state, parity computation and rx_parity_err logic are present.
- UART_RX_PARITY_EN undefined: PARITY_MODE is ignored, the PARITY state is never entered, and rx_parity_err is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - state encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5
  - PARITY_NONE/EVEN/ODD constants
  - the frame-length helper function
- The same package is reused by the future parametrised transmitter.
- One sub-module: uart_bit_sync, the 2-FF synchroniser with reset value 1.

## Test plan
All scenarios use CLKS_PER_BIT=16 and drive bits at exactly 16 clk per bit.
- 8N1, send 0x3F -> one rx_valid pulse, rx_data=0x3F, both error flags 0.
- DATA_BITS=7, PARITY_MODE=1 (even), STOP_BITS=2, send 0x55 with parity bit 0 -> rx_data=0x55, rx_parity_err=0. Repeat with parity bit 1 -> rx_parity_err=1.
- Low pulse of 4 cycles on an idle line -> no rx_valid, rx_busy returns to 0 within 12 cycles.
- 8N1, send 0xA5 with stop bit low, then hold the line low for 40 bits -> exactly one rx_valid with rx_data=0xA5 and rx_frame_err=1. No further rx_valid until the line goes high and a new frame is sent.
- Assert rst for 1 cycle in the middle of data bit 3 of 0xC3 -> no rx_valid for that frame. A following frame 0x81 is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x5A with no idle gap -> three rx_valid pulses with matching rx_data.
